// File: rtl/clock_gate_sequencer.sv
// clock_gate_sequencer: shared round-robin sequencer for per-node clock-gate cells.
// Each grant either toggles one gate, waits SETTLE_CYCLES, then acks, or acks a
// redundant request straight away. IDLE always separates two sequences.
// Optional build macro: CLOCK_GATE_SEQ_STOP_FIRST_EN (pending stops win arbitration).

// Per-node lane: request classification plus the node's gate and ack registers.
module clock_gate_node_lane (
    input  logic clock,
    input  logic async_resetn,
    input  logic starting,
    input  logic stopping,
    input  logic toggle,
    input  logic ack_start,
    input  logic ack_stop,
    output logic gate,
    output logic started,
    output logic stopped,
    output logic cand,
    output logic pend,
    output logic pend_stop,
    output logic is_start
);
    logic redundant;

    // Classify the request against the current gate; both-high resolves by gate state.
    always_comb begin
        is_start  = gate ? (starting & ~stopping) : starting;
        pend      = (starting & ~gate) | (stopping & gate);
        pend_stop = stopping & gate;
        redundant = (starting & gate) | (stopping & ~gate);
        cand      = pend | redundant;
    end

    // Gate flips only on a grant; acks are single-cycle registered pulses.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            gate    <= 1'b0;
            started <= 1'b0;
            stopped <= 1'b0;
        end else begin
            gate    <= gate ^ toggle;
            started <= ack_start;
            stopped <= ack_stop;
        end
    end
endmodule

module clock_gate_sequencer #(
    parameter int NODES         = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             async_resetn,
    input  logic [NODES-1:0] node_starting,
    input  logic [NODES-1:0] node_stopping,
    output logic [NODES-1:0] gate_enable,
    output logic [NODES-1:0] node_started,
    output logic [NODES-1:0] node_stopped,
    output logic             sequencer_busy
);
    localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Result of one arbitration pass.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic             is_start;
        logic             pend;
    } grant_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic             sel_start, sel_start_nxt;

    logic [NODES-1:0] cand, pend, pend_stop, is_start;
    logic [NODES-1:0] toggle, ack_start, ack_stop;
    logic [NODES-1:0] arb_mask;
    logic [IDX_W-1:0] arb_idx;
    grant_t           grant;

    clock_gate_node_lane u_lane [NODES-1:0] (
        .clock        (clock),
        .async_resetn (async_resetn),
        .starting     (node_starting),
        .stopping     (node_stopping),
        .toggle       (toggle),
        .ack_start    (ack_start),
        .ack_stop     (ack_stop),
        .gate         (gate_enable),
        .started      (node_started),
        .stopped      (node_stopped),
        .cand         (cand),
        .pend         (pend),
        .pend_stop    (pend_stop),
        .is_start     (is_start)
    );

    assign sequencer_busy = (state != IDLE);

    // Round-robin search from rr_ptr+1; optionally restricted to pending stops.
    always_comb begin
        arb_mask = cand;
`ifdef CLOCK_GATE_SEQ_STOP_FIRST_EN
        if (|pend_stop) arb_mask = pend_stop;
`endif
        grant   = '0;
        arb_idx = '0;
        for (int k = 1; k <= NODES; k++) begin
            arb_idx = IDX_W'((int'(rr_ptr) + k) % NODES);
            if (!grant.found && arb_mask[arb_idx]) begin
                grant.found    = 1'b1;
                grant.idx      = arb_idx;
                grant.is_start = is_start[arb_idx];
                grant.pend     = pend[arb_idx];
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= IDX_W'(NODES - 1);
            sel       <= '0;
            sel_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            sel       <= sel_nxt;
            sel_start <= sel_start_nxt;
        end
    end

    // Next state, gate toggle and ack requests; acks are registered in the lanes
    // so they appear in the cycle the FSM sits in ACK.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rr_ptr_nxt    = rr_ptr;
        sel_nxt       = sel;
        sel_start_nxt = sel_start;
        toggle        = '0;
        ack_start     = '0;
        ack_stop      = '0;
        unique case (state)
            IDLE: begin
                if (grant.found) begin
                    rr_ptr_nxt    = grant.idx;
                    sel_nxt       = grant.idx;
                    sel_start_nxt = grant.is_start;
                    if (grant.pend) begin
                        toggle[grant.idx] = 1'b1;
                        cnt_nxt           = '0;
                        state_nxt         = SETTLE;
                    end else begin
                        // Gate already in the requested state: acknowledge only.
                        ack_start[grant.idx] = grant.is_start;
                        ack_stop[grant.idx]  = ~grant.is_start;
                        state_nxt            = ACK;
                    end
                end
            end
            SETTLE: begin
                // Requests are ignored here; a withdrawn request still gets its ack.
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    ack_start[sel] = sel_start;
                    ack_stop[sel]  = ~sel_start;
                    state_nxt      = ACK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                // One IDLE cycle lets the acked node drop its request before re-arbitration.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Structural guarantees of the sequencer.
    a_one_ack : assert property (@(posedge clock) disable iff (!async_resetn)
        $onehot0(node_started | node_stopped));
    a_one_toggle : assert property (@(posedge clock) disable iff (!async_resetn)
        $onehot0(toggle));
endmodule

// File: tb/tb_clock_gate_sequencer.sv
// Bench for clock_gate_sequencer: directed scenarios plus random requests, checked
// by a transaction-level model that predicts each ack (cycle, node, kind, gate).
module tb_clock_gate_sequencer;
    localparam int N = 4;
    localparam int S = 4;
`ifdef CLOCK_GATE_SEQ_STOP_FIRST_EN
    localparam bit STOP_FIRST = 1'b1;
`else
    localparam bit STOP_FIRST = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         async_resetn = 1'b0;
    logic [N-1:0] node_starting = '0;
    logic [N-1:0] node_stopping = '0;
    logic [N-1:0] gate_enable, node_started, node_stopped;
    logic         sequencer_busy;

    clock_gate_sequencer #(.NODES(N), .SETTLE_CYCLES(S)) dut (
        .clock          (clock),
        .async_resetn   (async_resetn),
        .node_starting  (node_starting),
        .node_stopping  (node_stopping),
        .gate_enable    (gate_enable),
        .node_started   (node_started),
        .node_stopped   (node_stopped),
        .sequencer_busy (sequencer_busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        int           node;
        bit           start;
        logic [N-1:0] gate;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] m_gate;
    int           m_ptr, m_free, busy_lo, busy_hi;
    int           drop_at[N];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_flush();
        q.delete();
        m_gate  = '0;
        m_ptr   = N - 1;
        m_free  = 0;
        busy_lo = 1;
        busy_hi = 0;
        for (int i = 0; i < N; i++) drop_at[i] = -10;
    endfunction

    // Monitor (compare what the DUT shows this cycle), then model (predict new grant).
    always @(negedge clock) begin
        if (async_resetn) begin
            chk("busy", 32'(sequencer_busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ack cyc=%0d got=none exp=node%0d@%0d", cyc, q[0].node, q[0].cyc);
                void'(q.pop_front());
            end
            if (|(node_started | node_stopped)) begin
                chk("ack_onehot", 32'($countones(node_started | node_stopped)), 32'd1);
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack cyc=%0d got=%0h/%0h exp=none",
                             cyc, node_started, node_stopped);
                end else begin
                    exp_t e;
                    logic [N-1:0] oh;
                    e  = q.pop_front();
                    oh = N'(1) << e.node;
                    chk("ack_started", 32'(node_started), 32'(e.start ? oh : '0));
                    chk("ack_stopped", 32'(node_stopped), 32'(e.start ? '0 : oh));
                    chk("ack_gate", 32'(gate_enable), 32'(e.gate));
                end
            end

            if (cyc >= m_free) begin
                bit st[N], pd[N], cd[N];
                bit any_stop, found;
                int g;
                any_stop = 1'b0;
                found    = 1'b0;
                g        = 0;
                for (int i = 0; i < N; i++) begin
                    bit s, p;
                    s = node_starting[i];
                    p = node_stopping[i];
                    st[i] = (s && p) ? !m_gate[i] : s;
                    cd[i] = s || p;
                    pd[i] = cd[i] && (st[i] ? !m_gate[i] : m_gate[i]);
                    if (pd[i] && !st[i]) any_stop = 1'b1;
                end
                for (int k = 1; k <= N; k++) begin
                    int i;
                    bit elig;
                    i    = (m_ptr + k) % N;
                    elig = cd[i] && (!(STOP_FIRST && any_stop) || (pd[i] && !st[i]));
                    if (!found && elig) begin
                        found = 1'b1;
                        g     = i;
                    end
                end
                if (found) begin
                    exp_t e;
                    e.cyc  = pd[g] ? cyc + 1 + S : cyc + 1;
                    e.node = g;
                    e.start = st[g];
                    if (pd[g]) m_gate[g] = ~m_gate[g];
                    e.gate = m_gate;
                    q.push_back(e);
                    m_free     = e.cyc + 1;
                    busy_lo    = cyc + 1;
                    busy_hi    = e.cyc;
                    m_ptr      = g;
                    drop_at[g] = e.cyc;
                end
            end
        end
    end

    // Advance one cycle; a node drops its request the cycle after its ack.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (drop_at[i] == cyc - 1) begin
                node_starting[i] = 1'b0;
                node_stopping[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_cycles(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #3;
        async_resetn  = 1'b0;
        node_starting = '0;
        node_stopping = '0;
        model_flush();
        #1;
        chk("rst_gate", 32'(gate_enable), 32'd0);
        chk("rst_busy", 32'(sequencer_busy), 32'd0);
        chk("rst_ack", 32'(node_started | node_stopped), 32'd0);
        tick();
        tick();
        async_resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_flush();
        #2;
        chk("init_gate", 32'(gate_enable), 32'd0);
        chk("init_started", 32'(node_started), 32'd0);
        chk("init_stopped", 32'(node_stopped), 32'd0);
        chk("init_busy", 32'(sequencer_busy), 32'd0);
        tick();
        tick();
        async_resetn = 1'b1;
        tick();

        // single start
        node_starting[0] = 1'b1;
        wait_cycles(10);
        // return node 0 to off, then all four start together
        node_stopping[0] = 1'b1;
        wait_cycles(10);
        node_starting = '1;
        wait_cycles(30);
        // stop vs redundant start in the same cycle
        node_stopping[2] = 1'b1;
        node_starting[1] = 1'b1;
        wait_cycles(15);
        // pending stop then redundant stop on node 3
        node_stopping[3] = 1'b1;
        wait_cycles(10);
        node_stopping[3] = 1'b1;
        wait_cycles(5);
        // withdrawn start on node 1
        node_stopping[1] = 1'b1;
        wait_cycles(10);
        node_starting[1] = 1'b1;
        wait_cycles(3);
        node_starting[1] = 1'b0;
        wait_cycles(10);
        // reset during SETTLE, then node 0 must win first
        node_starting[2] = 1'b1;
        wait_cycles(3);
        mid_reset();
        node_starting[0] = 1'b1;
        node_starting[2] = 1'b1;
        wait_cycles(20);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!node_starting[i] && !node_stopping[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        int r;
                        r = $urandom_range(0, 3);
                        node_starting[i] = (r != 1);
                        node_stopping[i] = (r == 1 || r == 2);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    node_starting[i] = 1'b0;
                    node_stopping[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 599) == 0) mid_reset();
        end

        node_starting = '0;
        node_stopping = '0;
        wait_cycles(20);
        chk("end_queue", 32'(q.size()), 32'd0);
        chk("end_gate", 32'(gate_enable), 32'(m_gate));
        chk("end_busy", 32'(sequencer_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
